// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state type, constants and divider helper for the I2C byte writer
package i2c_pkg;

    typedef enum logic [2:0] {
        RECOVER,
        IDLE,
        START_A,
        START_B,
        BIT,
        ACK,
        STOP
    } state_e;

    localparam int RECOVER_PULSES = 9;

    // Quarter-period length in system clocks; never below one cycle
    function automatic int qdiv(input int clk_hz, input int i2c_hz, input bit sim);
        int q;
        if (sim) begin
            q = 2;
        end else begin
            q = clk_hz / (4 * i2c_hz);
        end
        if (q < 1) begin
            q = 1;
        end
        return q;
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - free-running quarter-period tick divider with clear and freeze
module i2c_qtick #(
    parameter int QDIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic freeze,
    output logic qtick
);

    localparam int W = $clog2(QDIV + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap;

    assign wrap  = (cnt_q == W'(QDIV - 1));
    assign qtick = wrap && !clear && !freeze;

    // Next count: held at zero by clear, stalled by freeze, wraps every QDIV cycles
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!freeze) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_byte_writer.sv
// rtl/i2c_byte_writer.sv - write-only I2C master (START, addr+W, one byte, STOP); I2C_CLK_STRETCH_EN enables slave clock stretching
module i2c_byte_writer
    import i2c_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int I2C_HZ = 100_000,
    parameter int SIM    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write_ena,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_out,
    output logic       scl_out,
    output logic       busy,
    output logic       error
);

    localparam int QDIV = qdiv(CLK_HZ, I2C_HZ, SIM != 0);

    state_e     state_q,  state_d;
    logic [1:0] qcnt_q,   qcnt_d;
    logic [3:0] bcnt_q,   bcnt_d;
    logic [7:0] shift_q,  shift_d;
    logic [7:0] data_q,   data_d;
    logic       second_q, second_d;
    logic       sda_q,    sda_d;
    logic       scl_q,    scl_d;
    logic       busy_q,   busy_d;
    logic       error_q,  error_d;

    logic       sda_meta_q, sda_sync_q;
    logic       qtick;
    logic       freeze;

    // Two-flop synchronizer for the SDA pin sense
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
        end
    end

`ifdef I2C_CLK_STRETCH_EN
    logic scl_meta_q, scl_sync_q;
    logic scl_high_entry;

    // Two-flop synchronizer for the SCL pin sense
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_in;
            scl_sync_q <= scl_meta_q;
        end
    end

    // Quarters in which SCL is released; stall there until the slave lets SCL rise
    assign scl_high_entry = (state_q == START_A)
                         || ((state_q == BIT || state_q == ACK || state_q == RECOVER) && qcnt_q == 2'd2)
                         || (state_q == STOP && qcnt_q == 2'd1);
    assign freeze = scl_high_entry && !scl_sync_q;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign freeze        = 1'b0;
`endif

    i2c_qtick #(
        .QDIV (QDIV)
    ) u_qtick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == IDLE),
        .freeze (freeze),
        .qtick  (qtick)
    );

    // Next state plus bus levels derived from the quarter being entered
    always_comb begin
        state_d  = state_q;
        qcnt_d   = qcnt_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        second_d = second_q;
        error_d  = error_q;

        case (state_q)
            RECOVER: begin
                if (qtick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    if (qcnt_q == 2'd3) begin
                        if (bcnt_q == 4'(RECOVER_PULSES - 1)) begin
                            state_d = STOP;
                            bcnt_d  = 4'd0;
                        end else begin
                            bcnt_d = bcnt_q + 4'd1;
                        end
                    end
                end
            end
            IDLE: begin
                if (write_ena) begin
                    state_d  = START_A;
                    qcnt_d   = 2'd0;
                    bcnt_d   = 4'd0;
                    shift_d  = {addr, 1'b0};
                    data_d   = data;
                    second_d = 1'b0;
                    error_d  = 1'b0;
                end
            end
            START_A: begin
                if (qtick) begin
                    state_d = START_B;
                end
            end
            START_B: begin
                if (qtick) begin
                    state_d = BIT;
                    qcnt_d  = 2'd0;
                    bcnt_d  = 4'd0;
                end
            end
            BIT: begin
                if (qtick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    if (qcnt_q == 2'd3) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        if (bcnt_q == 4'd7) begin
                            state_d = ACK;
                            bcnt_d  = 4'd0;
                        end else begin
                            bcnt_d = bcnt_q + 4'd1;
                        end
                    end
                end
            end
            ACK: begin
                if (qtick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    if (qcnt_q == 2'd3) begin
                        if (sda_sync_q) begin
                            error_d = 1'b1;
                            state_d = STOP;
                        end else if (!second_q) begin
                            shift_d  = data_q;
                            second_d = 1'b1;
                            state_d  = BIT;
                        end else begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (qtick) begin
                    if (qcnt_q == 2'd2) begin
                        state_d = IDLE;
                        qcnt_d  = 2'd0;
                    end else begin
                        qcnt_d = qcnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = RECOVER;
                qcnt_d  = 2'd0;
                bcnt_d  = 4'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
        sda_d  = 1'b1;
        scl_d  = 1'b1;
        case (state_d)
            RECOVER: scl_d = qcnt_d[1];
            START_B: sda_d = 1'b0;
            BIT: begin
                sda_d = shift_d[7];
                scl_d = qcnt_d[1];
            end
            ACK:     scl_d = qcnt_d[1];
            STOP: begin
                sda_d = (qcnt_d == 2'd2);
                scl_d = (qcnt_d != 2'd0);
            end
            default: begin
                sda_d = 1'b1;
                scl_d = 1'b1;
            end
        endcase
    end

    // FSM and registered bus outputs; reset releases the bus and schedules recovery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RECOVER;
            qcnt_q   <= 2'd0;
            bcnt_q   <= 4'd0;
            shift_q  <= 8'd0;
            data_q   <= 8'd0;
            second_q <= 1'b0;
            sda_q    <= 1'b1;
            scl_q    <= 1'b1;
            busy_q   <= 1'b1;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            qcnt_q   <= qcnt_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            second_q <= second_d;
            sda_q    <= sda_d;
            scl_q    <= scl_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
        end
    end

    assign sda_out = sda_q;
    assign scl_out = scl_q;
    assign busy    = busy_q;
    assign error   = error_q;

endmodule
